// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace buffer.
// Optional feature macro: RVFI_TRACE_MEM_EN adds memory-access fields to trace_rec_t.
package ibex_trace_pkg;

  localparam int unsigned OverflowCntW = 16;
  localparam int unsigned OrderW       = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FROZEN
  } trace_state_e;

  // One retired-instruction record as held in the buffer.
  typedef struct packed {
`ifdef RVFI_TRACE_MEM_EN
    logic [31:0]       mem_addr;
    logic [3:0]        mem_mask;
    logic              mem_we;
`endif
    logic [31:0]       pc;
    logic [31:0]       insn;
    logic [OrderW-1:0] order;
    logic [4:0]        rd_addr;
    logic [31:0]       rd_wdata;
    logic              trap;
    logic              gap;
  } trace_rec_t;

endpackage

// File: rtl/ibex_trace_fifo.sv
// Synchronous circular FIFO with extra-MSB pointers.
// Ports: clk_i/rst_ni clock and async active-low reset; clear flushes pointers;
// push/wdata write request; pop read request; rdata head entry; empty/full
// status; level occupancy.
module ibex_trace_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned PtrW  = AddrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [PtrW-1:0]  level
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr;
  logic [PtrW-1:0]  rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AddrW] != rptr[AddrW]) &&
                   (wptr[AddrW-1:0] == rptr[AddrW-1:0]);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign level   = wptr - rptr;
  assign rdata   = mem[rptr[AddrW-1:0]];

  // Pointers and storage; storage resets to zero so the head never reads X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem[AddrW'(i)] <= '0;
      end
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AddrW-1:0]] <= wdata;
        wptr                 <= wptr + PtrW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/ibex_rvfi_trace_buf.sv
// Captures RVFI retirement records into a circular buffer drained over valid/ready.
// Ports: clk_i/rst_ni clock and async active-low reset; enable_i capture enable;
// clear_i synchronous flush; rvfi_* retirement inputs; out_valid_o/out_ready_i/
// out_record_o drain port; level_o occupancy; overflow_cnt_o saturating drop
// count; frozen_o set while capture is frozen after a trap.
// Optional feature macro: RVFI_TRACE_MEM_EN stores memory-access info per record.
module ibex_rvfi_trace_buf
  import ibex_trace_pkg::*;
#(
  parameter int unsigned Depth      = 16,
  parameter bit          StopOnTrap = 1'b0,
  localparam int unsigned LvlW      = $clog2(Depth) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic                    rvfi_valid,
  input  logic [63:0]             rvfi_order,
  input  logic [31:0]             rvfi_insn,
  input  logic                    rvfi_trap,
  input  logic [31:0]             rvfi_pc_rdata,
  input  logic [4:0]              rvfi_rd_addr,
  input  logic [31:0]             rvfi_rd_wdata,
  input  logic [31:0]             rvfi_mem_addr,
  input  logic [3:0]              rvfi_mem_rmask,
  input  logic [3:0]              rvfi_mem_wmask,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output trace_rec_t              out_record_o,
  output logic [LvlW-1:0]         level_o,
  output logic [OverflowCntW-1:0] overflow_cnt_o,
  output logic                    frozen_o
);

  localparam int unsigned RecW = $bits(trace_rec_t);

  trace_state_e    state;
  trace_rec_t      rec;
  logic [RecW-1:0] fifo_rdata;
  logic            fifo_empty;
  logic            fifo_full;
  logic            gap_pending;
  logic            pop;
  logic            push_req;
  logic            push_ok;
  logic            drop;
  logic            unused_order;

  assign unused_order = ^rvfi_order[63:OrderW];

  assign pop      = out_valid_o & out_ready_i;
  assign push_req = (state == CAPTURE) & rvfi_valid;
  assign push_ok  = push_req & (~fifo_full | pop);
  assign drop     = push_req & fifo_full & ~pop;

  // Record packing.
  always_comb begin
    rec          = '0;
    rec.pc       = rvfi_pc_rdata;
    rec.insn     = rvfi_insn;
    rec.order    = rvfi_order[OrderW-1:0];
    rec.rd_addr  = rvfi_rd_addr;
    rec.rd_wdata = rvfi_rd_wdata;
    rec.trap     = rvfi_trap;
    rec.gap      = gap_pending;
`ifdef RVFI_TRACE_MEM_EN
    rec.mem_addr = rvfi_mem_addr;
    rec.mem_mask = rvfi_mem_rmask | rvfi_mem_wmask;
    rec.mem_we   = |rvfi_mem_wmask;
`endif
  end

`ifndef RVFI_TRACE_MEM_EN
  logic unused_mem;
  assign unused_mem = ^{rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask};
`endif

  ibex_trace_fifo #(
    .Depth (Depth),
    .Width (RecW)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (clear_i),
    .push   (push_ok),
    .wdata  (rec),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .level  (level_o)
  );

  assign out_valid_o  = ~fifo_empty;
  assign out_record_o = trace_rec_t'(fifo_rdata);

  // Capture FSM plus drop/gap accounting; clear overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      frozen_o       <= 1'b0;
      gap_pending    <= 1'b0;
      overflow_cnt_o <= '0;
    end else if (clear_i) begin
      state          <= enable_i ? CAPTURE : IDLE;
      frozen_o       <= 1'b0;
      gap_pending    <= 1'b0;
      overflow_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (StopOnTrap && push_ok && rvfi_trap) begin
            state    <= FROZEN;
            frozen_o <= 1'b1;
          end else if (!enable_i) begin
            state <= IDLE;
          end
        end
        FROZEN: begin
          state    <= FROZEN;
          frozen_o <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          frozen_o <= 1'b0;
        end
      endcase

      if (drop) begin
        gap_pending <= 1'b1;
        if (overflow_cnt_o != '1) begin
          overflow_cnt_o <= overflow_cnt_o + OverflowCntW'(1);
        end
      end else if (push_ok) begin
        gap_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
// Directed bench: two instances share stimulus, u_a with StopOnTrap=0 and
// u_b with StopOnTrap=1.
module tb_ibex_rvfi_trace_buf;
  import ibex_trace_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic [31:0] rvfi_pc;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  logic        out_ready;

  logic        valid_a, valid_b;
  trace_rec_t  rec_a, rec_b;
  logic [4:0]  level_a, level_b;
  logic [15:0] ovf_a, ovf_b;
  logic        frozen_a, frozen_b;

  int checks;
  int errors;

  ibex_rvfi_trace_buf #(.Depth(16), .StopOnTrap(1'b0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_pc_rdata(rvfi_pc), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .out_valid_o(valid_a), .out_ready_i(out_ready), .out_record_o(rec_a),
    .level_o(level_a), .overflow_cnt_o(ovf_a), .frozen_o(frozen_a)
  );

  ibex_rvfi_trace_buf #(.Depth(16), .StopOnTrap(1'b1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_pc_rdata(rvfi_pc), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .out_valid_o(valid_b), .out_ready_i(out_ready), .out_record_o(rec_b),
    .level_o(level_b), .overflow_cnt_o(ovf_b), .frozen_o(frozen_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present one retirement for exactly one clock edge; caller drops rvfi_valid.
  task automatic push_one(input logic [31:0] pc, input logic trap);
    rvfi_valid    = 1'b1;
    rvfi_pc       = pc;
    rvfi_insn     = pc ^ 32'h0000_0013;
    rvfi_order    = rvfi_order + 64'd1;
    rvfi_trap     = trap;
    rvfi_rd_addr  = pc[6:2];
    rvfi_rd_wdata = ~pc;
    step();
  endtask

  task automatic test_reset;
    trace_rec_t zero_rec;
    zero_rec = '0;
    checks++;
    if (valid_a !== 1'b0 || level_a !== 5'd0 || ovf_a !== 16'd0 || frozen_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a valid=%b level=%0d ovf=%0d frozen=%b exp 0/0/0/0",
               valid_a, level_a, ovf_a, frozen_a);
    end
    checks++;
    if (rec_a !== zero_rec) begin
      errors++;
      $display("FAIL reset_record got %h exp 0", rec_a);
    end
    checks++;
    if (valid_b !== 1'b0 || level_b !== 5'd0 || frozen_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b valid=%b level=%0d frozen=%b exp 0/0/0", valid_b, level_b, frozen_b);
    end
  endtask

  task automatic test_basic;
    logic [31:0] exp_pc;
    out_ready = 1'b0;
    push_one(32'h100, 1'b0);
    push_one(32'h104, 1'b0);
    push_one(32'h108, 1'b0);
    rvfi_valid = 1'b0;
    checks++;
    if (level_a !== 5'd3 || level_b !== 5'd3) begin
      errors++;
      $display("FAIL basic_level got a=%0d b=%0d exp 3", level_a, level_b);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h100 + 32'(4 * i);
      checks++;
      if (valid_a !== 1'b1 || rec_a.pc !== exp_pc || rec_a.gap !== 1'b0 ||
          rec_a.insn !== (exp_pc ^ 32'h13)) begin
        errors++;
        $display("FAIL basic_pop%0d got valid=%b pc=%h gap=%b insn=%h exp pc=%h gap=0",
                 i, valid_a, rec_a.pc, rec_a.gap, rec_a.insn, exp_pc);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (level_a !== 5'd0 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty got level=%0d valid=%b exp 0/0", level_a, valid_a);
    end
  endtask

  task automatic test_overflow_gap;
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) push_one(32'h1000 + 32'(4 * i), 1'b0);
    rvfi_valid = 1'b0;
    checks++;
    if (level_a !== 5'd16 || ovf_a !== 16'd4 || level_b !== 5'd16 || ovf_b !== 16'd4) begin
      errors++;
      $display("FAIL ovf_full got level=%0d/%0d ovf=%0d/%0d exp 16 and 4",
               level_a, level_b, ovf_a, ovf_b);
    end
    checks++;
    if (rec_a.pc !== 32'h1000 || rec_a.gap !== 1'b0) begin
      errors++;
      $display("FAIL ovf_head got pc=%h gap=%b exp 1000/0", rec_a.pc, rec_a.gap);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (level_a !== 5'd15) begin
      errors++;
      $display("FAIL ovf_pop1 got level=%0d exp 15", level_a);
    end
    push_one(32'h2000, 1'b0);
    rvfi_valid = 1'b0;
    checks++;
    if (level_a !== 5'd16 || ovf_a !== 16'd4) begin
      errors++;
      $display("FAIL ovf_refill got level=%0d ovf=%0d exp 16/4", level_a, ovf_a);
    end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] exp_pc;
    logic        exp_gap;
    out_ready = 1'b1;
    push_one(32'h3000, 1'b0);
    rvfi_valid = 1'b0;
    out_ready  = 1'b0;
    checks++;
    if (level_a !== 5'd16 || ovf_a !== 16'd4 || rec_a.pc !== 32'h1008) begin
      errors++;
      $display("FAIL full_pushpop got level=%0d ovf=%0d head=%h exp 16/4/1008",
               level_a, ovf_a, rec_a.pc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 14) begin
        exp_pc  = 32'h1008 + 32'(4 * i);
        exp_gap = 1'b0;
      end else if (i == 14) begin
        exp_pc  = 32'h2000;
        exp_gap = 1'b1;
      end else begin
        exp_pc  = 32'h3000;
        exp_gap = 1'b0;
      end
      checks++;
      if (valid_a !== 1'b1 || rec_a.pc !== exp_pc || rec_a.gap !== exp_gap) begin
        errors++;
        $display("FAIL drain%0d got valid=%b pc=%h gap=%b exp pc=%h gap=%b",
                 i, valid_a, rec_a.pc, rec_a.gap, exp_pc, exp_gap);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (valid_a !== 1'b0 || level_a !== 5'd0) begin
      errors++;
      $display("FAIL drain_empty got valid=%b level=%0d exp 0/0", valid_a, level_a);
    end
  endtask

  task automatic test_clear_push;
    push_one(32'h500, 1'b0);
    push_one(32'h504, 1'b0);
    clear = 1'b1;
    push_one(32'h508, 1'b0);
    clear      = 1'b0;
    rvfi_valid = 1'b0;
    checks++;
    if (level_a !== 5'd0 || ovf_a !== 16'd0 || valid_a !== 1'b0 ||
        level_b !== 5'd0 || ovf_b !== 16'd0) begin
      errors++;
      $display("FAIL clear_push got level=%0d/%0d ovf=%0d/%0d valid=%b exp all 0",
               level_a, level_b, ovf_a, ovf_b, valid_a);
    end
    push_one(32'h600, 1'b0);
    rvfi_valid = 1'b0;
    checks++;
    if (level_a !== 5'd1 || rec_a.pc !== 32'h600 || rec_a.gap !== 1'b0) begin
      errors++;
      $display("FAIL clear_after got level=%0d pc=%h gap=%b exp 1/600/0",
               level_a, rec_a.pc, rec_a.gap);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_freeze;
    push_one(32'h400, 1'b0);
    push_one(32'h404, 1'b1);
    push_one(32'h408, 1'b0);
    rvfi_valid = 1'b0;
    rvfi_trap  = 1'b0;
    checks++;
    if (level_b !== 5'd2 || frozen_b !== 1'b1) begin
      errors++;
      $display("FAIL freeze_b got level=%0d frozen=%b exp 2/1", level_b, frozen_b);
    end
    checks++;
    if (level_a !== 5'd3 || frozen_a !== 1'b0) begin
      errors++;
      $display("FAIL freeze_a got level=%0d frozen=%b exp 3/0", level_a, frozen_a);
    end
    out_ready = 1'b1;
    checks++;
    if (valid_b !== 1'b1 || rec_b.pc !== 32'h400 || rec_b.trap !== 1'b0) begin
      errors++;
      $display("FAIL freeze_pop0 got valid=%b pc=%h trap=%b exp 1/400/0", valid_b, rec_b.pc, rec_b.trap);
    end
    step();
    checks++;
    if (valid_b !== 1'b1 || rec_b.pc !== 32'h404 || rec_b.trap !== 1'b1) begin
      errors++;
      $display("FAIL freeze_pop1 got valid=%b pc=%h trap=%b exp 1/404/1", valid_b, rec_b.pc, rec_b.trap);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if (level_b !== 5'd0 || valid_b !== 1'b0 || frozen_b !== 1'b1 || level_a !== 5'd1) begin
      errors++;
      $display("FAIL freeze_drained got level_b=%0d valid_b=%b frozen_b=%b level_a=%0d exp 0/0/1/1",
               level_b, valid_b, frozen_b, level_a);
    end
    push_one(32'h40c, 1'b0);
    rvfi_valid = 1'b0;
    checks++;
    if (level_b !== 5'd0 || level_a !== 5'd2) begin
      errors++;
      $display("FAIL freeze_hold got level_b=%0d level_a=%0d exp 0/2", level_b, level_a);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (frozen_b !== 1'b0 || level_b !== 5'd0) begin
      errors++;
      $display("FAIL freeze_clear got frozen=%b level=%0d exp 0/0", frozen_b, level_b);
    end
    push_one(32'h410, 1'b0);
    rvfi_valid = 1'b0;
    checks++;
    if (level_b !== 5'd1 || rec_b.pc !== 32'h410) begin
      errors++;
      $display("FAIL freeze_recapture got level=%0d pc=%h exp 1/410", level_b, rec_b.pc);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_disable;
    enable = 1'b0;
    step();
    push_one(32'h700, 1'b0);
    rvfi_valid = 1'b0;
    checks++;
    if (level_a !== 5'd0 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL disable got level=%0d valid=%b exp 0/0", level_a, valid_a);
    end
    enable = 1'b1;
    step();
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) push_one(32'h800 + 32'(4 * i), 1'b0);
    rvfi_valid = 1'b0;
    checks++;
    if (level_a !== 5'd5) begin
      errors++;
      $display("FAIL reset_mid_pre got level=%0d exp 5", level_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_a !== 1'b0 || level_a !== 5'd0 || valid_b !== 1'b0 || level_b !== 5'd0 ||
        ovf_a !== 16'd0 || frozen_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b/%b level=%0d/%0d ovf=%0d frozen=%b exp all 0",
               valid_a, valid_b, level_a, level_b, ovf_a, frozen_b);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    enable         = 1'b0;
    clear          = 1'b0;
    rvfi_valid     = 1'b0;
    rvfi_order     = 64'd0;
    rvfi_insn      = 32'd0;
    rvfi_trap      = 1'b0;
    rvfi_pc        = 32'd0;
    rvfi_rd_addr   = 5'd0;
    rvfi_rd_wdata  = 32'd0;
    rvfi_mem_addr  = 32'd0;
    rvfi_mem_rmask = 4'd0;
    rvfi_mem_wmask = 4'd0;
    out_ready      = 1'b0;
    #1;
    test_reset();
    #6;
    rst_n  = 1'b1;
    enable = 1'b1;
    step();
    test_basic();
    test_overflow_gap();
    test_full_push_pop();
    test_clear_push();
    test_freeze();
    test_disable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_rvfi_trace_buf.md
# ibex_rvfi_trace_buf

Captures retired-instruction records from the core's RVFI retirement port into an on-chip circular buffer. A valid/ready drain port lets a debug or host agent read them back at its own pace. The block sits directly downstream of the core top-level RVFI outputs, in parallel with the simulation tracer, and is synthesizable so trace capture survives into FPGA builds. It provides lossy-but-accounted capture, plus an optional freeze-on-trap mode for post-mortem inspection.

## Interface
- `Depth`, 16, number of record slots; power of two, ≥2.
- `StopOnTrap`, 1'b0, when 1, capture freezes after storing the first trapping record.
- `clk_i` input 1: core clock; the only clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `enable_i` input 1: capture enable, level-sensitive.
- `clear_i` input 1: synchronous flush pulse.
- `rvfi_valid` input 1: retirement strobe.
- `rvfi_order` input 64: retirement index; low 16 bits are stored.
- `rvfi_insn` input 32: retired instruction word.
- `rvfi_trap` input 1: retirement trapped.
- `rvfi_pc_rdata` input 32: PC of the retired instruction.
- `rvfi_rd_addr` input 5: destination register.
- `rvfi_rd_wdata` input 32: destination write data.
- `rvfi_mem_addr`, `rvfi_mem_rmask`, `rvfi_mem_wmask` input 32/4/4: memory access info; used only under RVFI_TRACE_MEM_EN.
- `out_valid_o` output 1: head record available.
- `out_ready_i` input 1: consumer accepts the head record.
- `out_record_o` output `trace_rec_t`: head record.
- `level_o` output $clog2(Depth)+1: occupancy.
- `overflow_cnt_o` output 16: count of dropped retirements, saturating.
- `frozen_o` output 1: FSM is in FROZEN.

## Operation
- **FSM states:** IDLE, CAPTURE, FROZEN.
- **IDLE → CAPTURE:** when `enable_i`=1.
- **CAPTURE → IDLE:** when `enable_i`=0.
- **CAPTURE → FROZEN:** when `StopOnTrap`=1 and a record with `rvfi_trap`=1 is stored in the same cycle.
- **FROZEN exit:** only via `clear_i` or reset. `clear_i` goes to IDLE if `enable_i`=0, otherwise to CAPTURE.
- **Push:** in CAPTURE, `rvfi_valid`=1 stores the record at the write pointer.
- **Record fields:** `pc`, `insn`, `order[15:0]`, `rd_addr`, `rd_wdata`, `trap`, `gap`.
- **gap flag:** set to 1 on the first record stored after one or more drops, otherwise 0.
- **Full:** a push is accepted when not full, or when full and a pop occurs in the same cycle.
- **Drop:** a push when full with no pop is dropped. It increments `overflow_cnt_o` (saturates at 16'hFFFF) and sets the internal `gap_pending` flag.
- **Pop:** `out_valid_o && out_ready_i` advances the read pointer.
- **Draining:** continues in every state, including IDLE and FROZEN.
- **Empty:** `out_valid_o`=0. `out_record_o` is don't-care but must not be X-propagating after reset; storage resets to 0.
- **Wrap-around:** pointers are $clog2(Depth)+1 bits. Full = MSBs differ and LSBs are equal.
- **`clear_i`:** same cycle as push/pop → clear wins. Pointers, `level_o`, `overflow_cnt_o` and `gap_pending` are zeroed, and pending push/pop is discarded.
- **Reset values:** FSM=IDLE, `out_valid_o`=0, `level_o`=0, `overflow_cnt_o`=0, `frozen_o`=0, `out_record_o`=0.

## Timing
- **Push visibility:** a record pushed at edge N is visible on `out_record_o` with `out_valid_o`=1 from edge N onward, i.e. one cycle of latency with no combinational fall-through from `rvfi_*`.
- **Registered outputs:** `level_o`, `overflow_cnt_o` and `frozen_o` all update at the same edge as the push/pop that changes them.
- **Output stability:** `out_valid_o`/`out_record_o` hold stable until popped.
- **No combinational path** from `out_ready_i` to `out_valid_o`.
- **Throughput:** one push and one pop per cycle sustained.
- **Reset:** asserting `rst_ni` mid-operation clears everything immediately (asynchronously); deassertion is synchronized externally.

## Configuration
- **RVFI_TRACE_MEM_EN defined:** `trace_rec_t` gains `mem_addr` (32 bits) and a combined `mem_mask` (4 bits, `rmask|wmask`), plus a `mem_we` bit (1 when `wmask`≠0).
- **RVFI_TRACE_MEM_EN undefined:** these fields are absent, `rvfi_mem_*` ports are tied off internally into an unused signal, and the record width shrinks accordingly.

## Structure
- **Package `ibex_trace_pkg`:** holds `trace_rec_t` (packed struct, macro-dependent fields), the `trace_state_e` enum {IDLE, CAPTURE, FROZEN}, and `OverflowCntW`=16.
- **Sub-module `ibex_trace_fifo`:** a parameterized synchronous FIFO holding storage, pointers, full/empty and level.
- **Top module responsibilities:** FSM, drop/gap accounting and record packing.

## Test plan
- **Basic capture:** Depth=16, `enable_i`=1, retire 3 records with PCs 0x100/0x104/0x108, `out_ready_i`=0 → `level_o`=3; then with `out_ready_i`=1, pops return the PCs in order with `gap`=0.
- **Overflow and gap:** hold `out_ready_i`=0 and retire 20 records → `level_o`=16, `overflow_cnt_o`=4. Pop 1, then retire 1 more → that record has `gap`=1 and `level_o`=16.
- **Full with simultaneous push/pop:** with the buffer full, assert `rvfi_valid` and `out_ready_i` together → push accepted, `level_o` stays 16, `overflow_cnt_o` unchanged.
- **Freeze on trap:** with StopOnTrap=1, retire records with `trap`=0,1,0 → 2 stored and `frozen_o`=1. Draining still works. `clear_i` with `enable_i`=1 → CAPTURE, `level_o`=0.
- **Clear vs push:** `clear_i` and `rvfi_valid` in the same cycle → `level_o`=0 and `overflow_cnt_o`=0 next cycle.
- **Reset mid-stream:** assert `rst_ni`=0 with `level_o`=5 → `out_valid_o`=0 and `level_o`=0 immediately, without waiting for a clock edge.
